// File: rtl/lsl8_seq_if.sv
// Handshake and data bundle for the iterative 8-bit logical-shift-left unit.
// The master issues requests (start/d_in/shamt); the slave (the shifter)
// returns the registered result and its status flags.
interface lsl8_seq_if;
  logic       start;
  logic [7:0] d_in;
  logic [2:0] shamt;
  logic [7:0] d_out;
  logic       busy;
  logic       done;

  modport master (
    output start, d_in, shamt,
    input  d_out, busy, done
  );

  modport slave (
    input  start, d_in, shamt,
    output d_out, busy, done
  );
endinterface

// File: rtl/lsl8_seq.sv
// Iterative 8-bit logical shift left: one bit position per clock, zero fill
// at bit 0. A request is taken only in IDLE; the result register d_out is
// written exclusively on the edge that enters DONE, so it always holds the
// last completed result.
module lsl8_seq (
  input  logic         clk,
  input  logic         reset,
  lsl8_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] work_q, work_d;
  logic [7:0] dout_q, dout_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] work_shl;

  // One-position shift of the working value; reused for the final result so
  // d_out gets the value of the last shift step on the DONE-entry edge.
  assign work_shl = {work_q[6:0], 1'b0};

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= 8'h00;
      cnt_q   <= 3'd0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state and datapath update: load on accepted start, shift while
  // counting down, latch the result when the count is exhausted.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d = bus.d_in;
          cnt_d  = bus.shamt;
          if (bus.shamt == 3'd0) begin
            // Zero shift completes immediately with the operand unchanged.
            state_d = DONE;
            dout_d  = bus.d_in;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        // cnt is at least 1 here, so the decrement never wraps.
        work_d = work_shl;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = DONE;
          dout_d  = work_shl;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags decoded from the registered state only.
  always_comb begin
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.d_out = dout_q;
    if (state_q != IDLE) bus.busy = 1'b1;
    if (state_q == DONE) bus.done = 1'b1;
  end

endmodule

// File: doc/lsl8_seq.md
LSL8_SEQ -- requirements
Module: lsl8_seq

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 8 bits and the shift amount at 3 bits.
REQ-002 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  Asynchronous, active-high reset.
REQ-004 start  input  1  Request to begin a shift; sampled only in IDLE.
REQ-005 d_in  input  8  Operand, captured on the accepted start edge.
REQ-006 shamt  input  3  Left-shift amount 0..7, captured on the accepted start edge.
REQ-007 d_out  output  8  Registered result, the last completed logical-shift-left value.
REQ-008 busy  output  1  High in SHIFT and DONE states.
REQ-009 done  output  1  One-cycle pulse, high while in DONE state.

Function
REQ-010 The block SHALL be an iterative logical shift left (LSL) unit: one bit position per clock, zero fill at bit 0, bits leaving bit 7 discarded.
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL load work_reg<=d_in and cnt<=shamt on the clock edge.
REQ-013 On that start edge, the FSM SHALL move to DONE if shamt==0, else to SHIFT.
REQ-014 In SHIFT, each edge SHALL apply work_reg<={work_reg[6:0],1'b0} and cnt<=cnt-1.
REQ-015 In SHIFT, when cnt==1 on an edge, the shift SHALL complete and the FSM SHALL enter DONE on that same edge.
REQ-016 On the edge entering DONE, d_out SHALL load the final shifted value (d_in when shamt==0); d_out SHALL not change at any other time except reset.
REQ-017 DONE SHALL last exactly one cycle, followed unconditionally by IDLE.
REQ-018 Latency: done SHALL be high in the cycle following the (shamt+1)th rising edge counted from and including the start-accept edge.
REQ-019 start SHALL be ignored while busy=1 (SHIFT or DONE); d_in and shamt changes during busy SHALL have no effect.
REQ-020 A start asserted in the IDLE cycle right after DONE SHALL be accepted, giving back-to-back operation with one idle cycle between done pulses.
REQ-021 A held start in IDLE SHALL begin a new operation each time IDLE is reached; no edge detection is performed.
REQ-022 busy and done SHALL be decoded from registered state only, with no combinational path from start.
REQ-023 cnt SHALL be 3 bits and never wrap below 0; SHIFT is never entered with cnt==0.

Reset
REQ-024 While reset=1, asynchronously: state=IDLE, work_reg=0, cnt=0, d_out=8'h00, busy=0, done=0.
REQ-025 Reset asserted mid-operation (SHIFT or DONE) SHALL abort the operation; no done pulse follows and d_out=8'h00.
REQ-026 After reset deassertion, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 d_in=8'hB5, shamt=0, start pulse -> done high in the cycle after 1 edge, d_out=8'hB5, busy high 1 cycle.
REQ-028 d_in=8'h81, shamt=3, start pulse -> busy for 4 cycles, done after the 4th edge, d_out=8'h08.
REQ-029 d_in=8'hFF, shamt=7 -> done after 8 edges, d_out=8'h80; a start with d_in=8'h01 and shamt=1 mid-shift is ignored.
REQ-030 start held high, d_in=8'h0F, shamt=2 -> done pulses every 4 cycles (3 busy plus 1 idle), d_out=8'h3C each time.
REQ-031 d_in=8'hAA, shamt=5, reset asserted asynchronously between edges during SHIFT -> outputs zero immediately, no done pulse; after release, d_in=8'h03 and shamt=1 give d_out=8'h06.
REQ-032 Exhaustive sweep of d_in 0..255 and shamt 0..7 -> d_out equals (d_in<<shamt)&8'hFF, and latency equals shamt+1 edges, for every case.
